// File: rtl/icache_refill_unit_pkg.sv
// Shared types and constants for the instruction-cache refill path.
// Burst geometry helpers derive beat count and offset width from the line size.
package icache_refill_unit_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, WRITE} refill_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int beats_of(input int block_w, input int data_w);
    return block_w / data_w;
  endfunction

  function automatic int ofs_of(input int block_w);
    return $clog2(block_w / 8);
  endfunction

  // A single-beat line still needs a one-bit counter to keep the types legal.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/icache_refill_unit.sv
// AXI4 read master that fetches one cache line per icache miss and
// presents it to the icache write port as a single-cycle strobe.
module icache_refill_unit
  import icache_refill_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                   i_clk,
  input  logic                   i_arstn,
  input  logic                   i_miss,
  input  logic [ADDR_WIDTH-1:0]  i_read_addr,
  output logic                   o_ar_valid,
  input  logic                   i_ar_ready,
  output logic [ADDR_WIDTH-1:0]  o_ar_addr,
  output logic [7:0]             o_ar_len,
  output logic [2:0]             o_ar_size,
  output logic [1:0]             o_ar_burst,
  input  logic                   i_r_valid,
  output logic                   o_r_ready,
  input  logic [DATA_WIDTH-1:0]  i_r_data,
  input  logic [1:0]             i_r_resp,
  input  logic                   i_r_last,
  output logic                   o_instr_we,
  output logic [BLOCK_WIDTH-1:0] o_instr_block,
  output logic                   o_stall,
  output logic                   o_error
);

  localparam int BEATS = beats_of(BLOCK_WIDTH, DATA_WIDTH);
  localparam int OFS   = ofs_of(BLOCK_WIDTH);
  localparam int CW    = cnt_width(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK =
    ~ADDR_WIDTH'((64'd1 << OFS) - 64'd1);

  refill_state_t          state_reg;
  logic [CW-1:0]          beat_cnt_reg;
  logic [BLOCK_WIDTH-1:0] line_reg;

  assign o_ar_len      = 8'(BEATS - 1);
  assign o_ar_size     = 3'($clog2(DATA_WIDTH / 8));
  assign o_ar_burst    = AXI_BURST_INCR;
  assign o_instr_block = line_reg;
  // Combinational in IDLE so fetch freezes in the very cycle of the miss.
  assign o_stall       = i_miss | (state_reg != IDLE);

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      line_reg     <= '0;
      o_ar_addr    <= '0;
      o_ar_valid   <= 1'b0;
      o_r_ready    <= 1'b0;
      o_instr_we   <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_miss) begin
            o_ar_addr    <= i_read_addr & BLOCK_MASK;
            beat_cnt_reg <= '0;
            o_ar_valid   <= 1'b1;
            state_reg    <= ADDR;
          end
        end
        ADDR: begin
          if (i_ar_ready) begin
            o_ar_valid <= 1'b0;
            o_r_ready  <= 1'b1;
            state_reg  <= DATA;
          end
        end
        DATA: begin
          if (i_r_valid) begin
            line_reg[beat_cnt_reg*DATA_WIDTH +: DATA_WIDTH] <= i_r_data;
            if (i_r_resp != AXI_RESP_OKAY) o_error <= 1'b1;
            if (beat_cnt_reg == LAST_BEAT) begin
              if (!i_r_last) o_error <= 1'b1;
              o_r_ready  <= 1'b0;
              o_instr_we <= 1'b1;
              state_reg  <= WRITE;
            end else if (i_r_last) begin
              // Truncated burst: the partial line is never written.
              o_error   <= 1'b1;
              o_r_ready <= 1'b0;
              state_reg <= IDLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        WRITE: begin
          o_instr_we <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Randomized scoreboard bench for icache_refill_unit: the stimulus task predicts
// AR addresses and assembled lines, negedge monitors pop and compare them.
module tb_icache_refill_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss;
  logic [63:0]  read_addr;
  logic         ar_valid;
  logic         ar_ready;
  logic [63:0]  ar_addr;
  logic [7:0]   ar_len;
  logic [2:0]   ar_size;
  logic [1:0]   ar_burst;
  logic         r_valid;
  logic         r_ready;
  logic [63:0]  r_data;
  logic [1:0]   r_resp;
  logic         r_last;
  logic         instr_we;
  logic [511:0] instr_block;
  logic         stall;
  logic         error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_cyc = 0;
  logic err_m = 1'b0;

  logic [63:0]  exp_ar_q[$];
  logic [511:0] exp_blk_q[$];

  icache_refill_unit dut (
    .i_clk(clk), .i_arstn(rst_n), .i_miss(miss), .i_read_addr(read_addr),
    .o_ar_valid(ar_valid), .i_ar_ready(ar_ready), .o_ar_addr(ar_addr),
    .o_ar_len(ar_len), .o_ar_size(ar_size), .o_ar_burst(ar_burst),
    .i_r_valid(r_valid), .o_r_ready(r_ready), .i_r_data(r_data),
    .i_r_resp(r_resp), .i_r_last(r_last), .o_instr_we(instr_we),
    .o_instr_block(instr_block), .o_stall(stall), .o_error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: AR handshakes and line writes are matched against predictions.
  always @(negedge clk) begin
    if (rst_n && ar_valid && ar_ready) begin
      if (exp_ar_q.size() == 0) chk("ar_unexpected", ar_valid, 1'b0);
      else begin
        logic [63:0] a;
        a = exp_ar_q.pop_front();
        chk("ar_addr", ar_addr, a);
        chk("ar_len", ar_len, 8'd7);
        chk("ar_size", ar_size, 3'd3);
        chk("ar_burst", ar_burst, 2'b01);
        $display("AR  addr=%h len=%0d size=%0d burst=%0d", ar_addr, ar_len, ar_size, ar_burst);
      end
    end
    if (rst_n && instr_we) begin
      we_cyc = cyc;
      if (exp_blk_q.size() == 0) chk("we_unexpected", instr_we, 1'b0);
      else begin
        logic [511:0] b;
        b = exp_blk_q.pop_front();
        chk("instr_block", instr_block, b);
        $display("WE  block[63:0]=%h block[511:448]=%h", instr_block[63:0], instr_block[511:448]);
      end
    end
  end

  task automatic refill(input logic [63:0] addr, input int ar_wait, input int gap_mode,
                        input int bad_beat, input int early_last, input int rst_beat,
                        input bit fixed);
    logic [63:0]  beats[8];
    logic [511:0] blk;
    logic [63:0]  aaddr;
    int n, miss_cyc, t, gaps;
    aaddr = addr & ~64'h3f;
    blk = '0;
    for (int k = 0; k < 8; k++) begin
      beats[k] = fixed ? 64'h1111_1111_1111_1111 + 64'(k) : {$urandom, $urandom};
      blk[k*64 +: 64] = beats[k];
    end
    n = (early_last >= 0) ? early_last + 1 : 8;
    exp_ar_q.push_back(aaddr);
    if (early_last < 0 && rst_beat < 0) exp_blk_q.push_back(blk);

    miss = 1'b1;
    read_addr = addr;
    miss_cyc = cyc;
    #1 chk("stall_on_miss", stall, 1'b1);
    @(posedge clk); #1;
    miss = 1'b0;
    read_addr = {$urandom, $urandom};

    t = 0;
    while (!ar_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ar_valid_up", ar_valid, 1'b1);
    for (int w = 0; w < ar_wait; w++) begin
      chk("ar_hold_valid", ar_valid, 1'b1);
      chk("ar_hold_addr", ar_addr, aaddr);
      @(posedge clk); #1;
    end
    ar_ready = 1'b1;
    @(posedge clk); #1;
    ar_ready = 1'b0;
    chk("ar_single_handshake", ar_valid, 1'b0);

    for (int k = 0; k < n; k++) begin
      gaps = (gap_mode == 1) ? ((k > 0) ? 2 : 0) :
             (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      r_valid = 1'b0;
      r_data = {$urandom, $urandom};
      repeat (gaps) begin
        @(posedge clk); #1;
      end
      r_valid = 1'b1;
      r_data = beats[k];
      r_resp = (k == bad_beat) ? 2'b10 : 2'b00;
      r_last = (k == n - 1);
      if (k == bad_beat || k == early_last) err_m = 1'b1;
      chk("r_ready", r_ready, 1'b1);
      chk("stall_busy", stall, 1'b1);
      @(posedge clk); #1;
      if (k == rst_beat) begin
        r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
        rst_n = 1'b0;
        err_m = 1'b0;
        #1;
        chk("rst_ar_valid", ar_valid, 1'b0);
        chk("rst_r_ready", r_ready, 1'b0);
        chk("rst_we", instr_we, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_ar_addr", ar_addr, 64'd0);
        chk("rst_block", instr_block, 512'd0);
        chk("rst_stall", stall, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("RST mid-burst after beat %0d", k);
        return;
      end
    end
    r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;

    if (early_last >= 0) begin
      chk("early_no_we", instr_we, 1'b0);
      chk("early_idle", stall, 1'b0);
      chk("early_r_ready", r_ready, 1'b0);
      @(posedge clk); #1;
    end else begin
      chk("we_pulse", instr_we, 1'b1);
      chk("stall_in_we", stall, 1'b1);
      @(posedge clk); #1;
      chk("we_single", instr_we, 1'b0);
      chk("stall_after_we", stall, 1'b0);
      if (fixed) chk("latency", 32'(we_cyc - miss_cyc), 32'd10);
    end
    chk("error_flag", error, err_m);
    $display("TXN addr=%h ar_wait=%0d gaps=%0d bad=%0d early=%0d error=%0d",
             addr, ar_wait, gap_mode, bad_beat, early_last, error);
  endtask

  initial begin
    rst_n = 1'b0; miss = 1'b0; read_addr = '0; ar_ready = 1'b0;
    r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ar_valid", ar_valid, 1'b0);
    chk("reset_r_ready", r_ready, 1'b0);
    chk("reset_we", instr_we, 1'b0);
    chk("reset_error", error, 1'b0);
    chk("reset_stall", stall, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    refill(64'h8000_0024, 0, 0, -1, -1, -1, 1'b1);
    refill({$urandom, $urandom}, 5, 0, -1, -1, -1, 1'b0);
    refill({$urandom, $urandom}, 0, 1, -1, -1, -1, 1'b0);
    for (int i = 0; i < 6; i++)
      refill({$urandom, $urandom}, int'($urandom_range(0, 3)), 2, -1, -1, -1, 1'b0);
    refill({$urandom, $urandom}, 0, 0, 3, -1, -1, 1'b0);
    refill({$urandom, $urandom}, 1, 2, -1, -1, -1, 1'b0);
    refill({$urandom, $urandom}, 0, 0, -1, 4, -1, 1'b0);
    refill({$urandom, $urandom}, 0, 0, -1, -1, -1, 1'b0);
    refill({$urandom, $urandom}, 0, 0, -1, -1, 2, 1'b0);
    refill({$urandom, $urandom}, 0, 2, -1, -1, -1, 1'b0);
    refill({$urandom, $urandom}, 2, 2, -1, -1, -1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("ar_queue_drained", 32'(exp_ar_q.size()), 32'd0);
    chk("blk_queue_drained", 32'(exp_blk_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache_refill_unit.md
Name: icache_refill_unit

Overview:
- AXI4 read-master that services instruction-cache misses for the fetch stage.
- Takes the miss flag and the fetch read address, and issues one INCR burst for the enclosing cache block.
- Assembles the returned DATA_WIDTH beats into one BLOCK_WIDTH line, then pulses the cache write-enable with the assembled block.
- Holds fetch stalled for the whole refill; it is the memory-side counterpart of the icache write port.

Parameters:
- ADDR_WIDTH, 64, address width of the fetch read address and AXI AR channel.
- BLOCK_WIDTH, 512, cache line width in bits.
- DATA_WIDTH, 64, AXI read data bus width. BLOCK_WIDTH must be an integer multiple of DATA_WIDTH.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_arstn  input  1  reset, asynchronous, active-low.
- i_miss  input  1  icache miss for the current fetch (inverse of the icache hit).
- i_read_addr  input  ADDR_WIDTH  fetch PC / AXI read address from the fetch stage.
- o_ar_valid  output  1  AXI AR valid.
- i_ar_ready  input  1  AXI AR ready.
- o_ar_addr  output  ADDR_WIDTH  block-aligned burst address.
- o_ar_len  output  8  burst length minus 1, constant BEATS-1.
- o_ar_size  output  3  constant log2(DATA_WIDTH/8); 3'b011 at default.
- o_ar_burst  output  2  constant 2'b01 (INCR).
- i_r_valid  input  1  AXI R valid.
- o_r_ready  output  1  AXI R ready.
- i_r_data  input  DATA_WIDTH  AXI read data.
- i_r_resp  input  2  AXI read response.
- i_r_last  input  1  AXI last beat.
- o_instr_we  output  1  single-cycle cache line write strobe.
- o_instr_block  output  BLOCK_WIDTH  assembled line, valid while o_instr_we=1.
- o_stall  output  1  fetch stall request.
- o_error  output  1  sticky bus/protocol error flag.

Behaviour:
- Derived values:
  - BEATS = BLOCK_WIDTH/DATA_WIDTH (8 at default).
  - OFS = log2(BLOCK_WIDTH/8) (6 at default).
  - beat counter width is log2(BEATS).
- State machine IDLE, ADDR, DATA, WRITE. Reset state is IDLE.
- Reset values: o_ar_valid=0, o_r_ready=0, o_instr_we=0, o_error=0, o_ar_addr=0, block buffer=0, beat counter=0.
- IDLE:
  - If i_miss=1, latch o_ar_addr = i_read_addr with low OFS bits cleared, clear the beat counter, and go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - o_ar_valid=1; o_ar_addr is held stable.
  - On i_ar_ready=1, go to DATA (AR handshake completes at that edge).
  - Valid is never dropped before ready.
- DATA:
  - o_r_ready=1. A beat is accepted when i_r_valid=1.
  - Beat k is written to buffer bits [k*DATA_WIDTH +: DATA_WIDTH]; beat 0 lands at the LSBs.
  - The counter increments per accepted beat and does not wrap within a burst.
  - i_r_resp != 0 on any beat sets o_error; the burst continues.
  - Beat BEATS-1 accepted: go to WRITE. If i_r_last=0 on that beat, set o_error.
  - i_r_last=1 on beat k < BEATS-1: set o_error and return to IDLE without writing. The line is discarded.
- WRITE:
  - o_instr_we=1 for exactly one cycle with o_instr_block = buffer, then go to IDLE.
  - The line is written even when a resp error occurred; o_error reports the failure.
- o_stall = i_miss OR (state != IDLE). The stall is combinational in IDLE, so fetch freezes in the miss cycle.
- In the cycle after WRITE, the icache reflects the new line. A fresh i_miss in IDLE (e.g. PC redirected by a mispredict during refill) starts a new refill. No refill is ever aborted mid-burst.
- Latency: refill starts at the edge after miss, and o_instr_we rises after AR handshake + BEATS beats + 1 cycle. Minimum is miss to we = BEATS+2 cycles with zero wait states.
- o_error clears only on reset.
- Asynchronous reset mid-burst returns the FSM to IDLE and all outputs to reset values immediately. The interconnect is reset together.

Decomposition:
- Shared package holds:
  - enum refill_state_t {IDLE, ADDR, DATA, WRITE};
  - AXI constants AXI_BURST_INCR=2'b01 and AXI_RESP_OKAY=2'b00;
  - localparam helpers for BEATS/OFS.
- Single module. The beat-assembly buffer stays inline; no sub-module.

Test Plan:
- Zero-wait refill:
  - Stimulus: i_miss=1, i_read_addr=0x80000024; ar_ready=1; beats 0x1111..+k for k=0..7 back-to-back, last on beat 7.
  - Response: o_ar_addr=0x80000000, len=7, size=3, burst=1. o_instr_we pulses once on cycle 10 with block[63:0]=beat0 and block[511:448]=beat7; o_stall is high from miss until the cycle after we.
- AR backpressure:
  - Stimulus: i_ar_ready held 0 for 5 cycles.
  - Response: o_ar_valid stays 1 and o_ar_addr stays stable throughout; exactly one handshake occurs.
- R gaps:
  - Stimulus: i_r_valid toggles 1,0,0,1...
  - Response: only valid beats are counted; the block matches the ordered payload and we fires once.
- Error response:
  - Stimulus: beat 3 returns resp=2'b10.
  - Response: o_error=1 and remains set; the line is still written.
- Early last:
  - Stimulus: r_last=1 on beat 4.
  - Response: o_error=1, no o_instr_we, FSM returns to IDLE, and a new i_miss starts a clean burst.
- Reset mid-burst:
  - Stimulus: i_arstn=0 after beat 2.
  - Response: all outputs go to reset values asynchronously; after release with i_miss=1, a new AR is issued with a fresh beat count.
